ldo_trim_ctrl: RTL and testbench



---
 rtl/ldo_trim_ctrl.sv | 136 +++++++++++++
 tb/tb_ldo_trim_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ldo_trim_ctrl.sv
// Wishbone-programmable one-hot trim sequencer for a bank of LDO channels.
// Walks each channel's active trim bit one position per shared step tick toward its target.
module ldo_trim_ctrl #(
  parameter int          NCH       = 3,
  parameter int          TRIM_W    = 16,
  parameter int          RESET_IDX = 6,
  parameter int          DIV_RST   = 3,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic [NCH*TRIM_W-1:0] trim_o,
  output logic [NCH-1:0]        busy_o,
  output logic                  irq_o
);
  localparam int IW = $clog2(TRIM_W);

  logic [IW-1:0] cur_q [NCH];
  logic [IW-1:0] cur_d [NCH];
  logic [IW-1:0] tgt_q [NCH];
  logic [IW-1:0] tgt_d [NCH];
  logic [15:0]   div_q, div_d;
  logic [15:0]   tmr_q, tmr_d;
  logic          irq_q, irq_d;
  logic          busy_any_q;
  logic          hold_q, hold_d;
  logic          ack_q;
  logic [31:0]   dat_q, dat_d;

  logic          in_range, accept, wr_acc, busy_any, tick;
  logic [5:0]    off;
  logic          is_tgt, is_div, is_stat;
  logic [31:0]   rdata;
  logic          unused_ok;

  assign unused_ok = ^{wbs_sel_i[2], wbs_adr_i[1:0], wbs_dat_i[30:16]};

  // A held strobe is acked once; hold_q blocks re-acceptance until stb drops.
  assign in_range = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign accept   = in_range && !hold_q;
  assign wr_acc   = accept && wbs_we_i;
  assign off      = wbs_adr_i[7:2];
  assign is_tgt   = (off[5:4] == 2'b00) && (int'(off[3:0]) < NCH);
  assign is_div   = (off == 6'h10);
  assign is_stat  = (off == 6'h11);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign busy_o[c] = (cur_q[c] != tgt_q[c]);
    assign trim_o[c*TRIM_W +: TRIM_W] = {{(TRIM_W-1){1'b0}}, 1'b1} << cur_q[c];
  end

  assign busy_any  = |busy_o;
  assign tick      = busy_any && (tmr_q == div_q);
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = irq_q;

  always_comb begin
    rdata = '0;
    if (is_tgt) begin
      for (int c = 0; c < NCH; c++) begin
        if (int'(off[3:0]) == c) begin
          rdata[IW-1:0]  = tgt_q[c];
          rdata[16 +: IW] = cur_q[c];
        end
      end
    end else if (is_div) begin
      rdata[15:0] = div_q;
    end else if (is_stat) begin
      rdata[NCH-1:0] = busy_o;
      rdata[31]      = irq_q;
    end
  end

  always_comb begin
    div_d = div_q;
    if (wr_acc && is_div) begin
      if (wbs_sel_i[0]) div_d[7:0]  = wbs_dat_i[7:0];
      if (wbs_sel_i[1]) div_d[15:8] = wbs_dat_i[15:8];
    end
    tmr_d = (!busy_any || tick) ? 16'd0 : tmr_q + 16'd1;

    // Step direction follows the incoming target so a same-edge retarget never overshoots.
    for (int c = 0; c < NCH; c++) begin
      tgt_d[c] = tgt_q[c];
      if (wr_acc && is_tgt && wbs_sel_i[0] && (int'(off[3:0]) == c))
        tgt_d[c] = wbs_dat_i[IW-1:0];
      cur_d[c] = cur_q[c];
      if (tick && busy_o[c]) begin
        if (cur_q[c] < tgt_d[c])      cur_d[c] = cur_q[c] + 1'b1;
        else if (cur_q[c] > tgt_d[c]) cur_d[c] = cur_q[c] - 1'b1;
      end
    end

    irq_d = irq_q;
    if (wr_acc && is_stat && wbs_sel_i[3] && wbs_dat_i[31]) irq_d = 1'b0;
    if (busy_any_q && !busy_any)                              irq_d = 1'b1;

    hold_d = accept || (hold_q && wbs_stb_i);
    dat_d  = (accept && !wbs_we_i) ? rdata : 32'd0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        cur_q[c] <= IW'(RESET_IDX);
        tgt_q[c] <= IW'(RESET_IDX);
      end
      div_q      <= 16'(DIV_RST);
      tmr_q      <= 16'd0;
      irq_q      <= 1'b0;
      busy_any_q <= 1'b0;
      hold_q     <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= 32'd0;
    end else begin
      cur_q      <= cur_d;
      tgt_q      <= tgt_d;
      div_q      <= div_d;
      tmr_q      <= tmr_d;
      irq_q      <= irq_d;
      busy_any_q <= busy_any;
      hold_q     <= hold_d;
      ack_q      <= accept;
      dat_q      <= dat_d;
    end
  end
endmodule

// File: tb/tb_ldo_trim_ctrl.sv
// Bench for ldo_trim_ctrl: table-driven walk checks, read scoreboard, bus and reset corner cases.
module tb_ldo_trim_ctrl;
  localparam int NCH = 3;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stb, cyc, we;
  logic [3:0]        sel;
  logic [31:0]       adr, wdat;
  logic              ack;
  logic [31:0]       rdat;
  logic [NCH*16-1:0] trim;
  logic [NCH-1:0]    busy;
  logic              irq;

  int checks = 0;
  int errors = 0;

  typedef struct { string name; logic [31:0] dat; } exp_t;
  exp_t sb[$];

  typedef struct { int k; logic [15:0] trim; logic busy; logic irq; } vec_t;
  vec_t vt[8];

  ldo_trim_ctrl #(.NCH(NCH), .TRIM_W(16), .RESET_IDX(6), .DIV_RST(3), .BASE_ADDR(BASE)) dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .trim_o   (trim),
    .busy_o   (busy),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reads push their expected data when driven and pop it when the ack arrives.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] exp, input string name);
    logic got;
    logic [31:0] rd;
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    if (!w) sb.push_back('{name, exp});
    got = 1'b0;
    rd  = 32'd0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk);
      #1;
      got = ack;
      rd  = rdat;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_ack: got no ack expected ack within 4 cycles", name);
    end
    if (!w && sb.size() > 0) begin
      e = sb.pop_front();
      if (got) chk(e.name, rd, e.dat);
    end
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      checks++;
      if (!$onehot(trim[c*16 +: 16])) begin
        errors++;
        $display("FAIL onehot_ch%0d: got 0x%0h expected a single set bit", c, trim[c*16 +: 16]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int n;
    vt[0] = '{0,  16'h0040, 1'b1, 1'b0};
    vt[1] = '{3,  16'h0040, 1'b1, 1'b0};
    vt[2] = '{4,  16'h0080, 1'b1, 1'b0};
    vt[3] = '{7,  16'h0080, 1'b1, 1'b0};
    vt[4] = '{8,  16'h0100, 1'b1, 1'b0};
    vt[5] = '{11, 16'h0100, 1'b1, 1'b0};
    vt[6] = '{12, 16'h0200, 1'b0, 1'b0};
    vt[7] = '{13, 16'h0200, 1'b0, 1'b1};

    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; wdat = 32'd0;
    #12;
    chk("rst_trim", trim, {3{16'h0040}});
    chk("rst_busy", busy, 3'b000);
    chk("rst_irq", irq, 1'b0);
    chk("rst_ack", ack, 1'b0);
    chk("rst_dat", rdat, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wb_xfer(1'b0, BASE + 32'h40, 32'd0, 4'hF, 32'd3, "rd_div_rst");

    // Upward walk on ch0, DIV=3: one step every 4 cycles.
    wb_xfer(1'b1, BASE + 32'h00, 32'd9, 4'b0001, 32'd0, "wr_tgt0_9");
    idx = 0;
    for (int k = 0; k <= 13; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      while (idx < 8 && vt[idx].k == k) begin
        chk($sformatf("walk_k%0d_trim", k), trim[15:0], vt[idx].trim);
        chk($sformatf("walk_k%0d_busy", k), busy[0], vt[idx].busy);
        chk($sformatf("walk_k%0d_irq", k), irq, vt[idx].irq);
        idx++;
      end
    end
    wb_xfer(1'b0, BASE + 32'h44, 32'd0, 4'hF, 32'h8000_0000, "rd_status_irq");
    wb_xfer(1'b1, BASE + 32'h44, 32'h8000_0000, 4'b1000, 32'd0, "wr_irq_clr");
    wb_xfer(1'b0, BASE + 32'h44, 32'd0, 4'hF, 32'h0000_0000, "rd_status_clr");
    wb_xfer(1'b0, BASE + 32'h00, 32'd0, 4'hF, 32'h0009_0009, "rd_tgt0");

    // Retarget ch1 mid-walk: 6 -> up toward 12, reversed to 4 at cur=8.
    wb_xfer(1'b1, BASE + 32'h04, 32'd12, 4'b0001, 32'd0, "wr_tgt1_12");
    repeat (8) @(posedge clk);
    #1;
    chk("rt_cur8", trim[31:16], 16'h0100);
    wb_xfer(1'b1, BASE + 32'h04, 32'd4, 4'b0001, 32'd0, "wr_tgt1_4");
    repeat (2) @(posedge clk);
    #1;
    chk("rt_cur7", trim[31:16], 16'h0080);
    chk("rt_busy_mid", busy, 3'b010);
    repeat (12) @(posedge clk);
    #1;
    chk("rt_cur4", trim[31:16], 16'h0010);
    chk("rt_busy_done", busy, 3'b000);
    @(posedge clk);
    #1;
    chk("rt_irq", irq, 1'b1);

    // Bus corners.
    wb_xfer(1'b0, BASE + 32'h80, 32'd0, 4'hF, 32'd0, "rd_hole");
    @(posedge clk);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h100; sel = 4'hF;
    n = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (ack) n++;
    end
    stb = 1'b0; cyc = 1'b0;
    chk("oor_acks", n, 0);
    @(posedge clk);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h44; sel = 4'hF;
    n = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (ack) n++;
    end
    stb = 1'b0; cyc = 1'b0;
    chk("held_stb_acks", n, 1);
    wb_xfer(1'b1, BASE + 32'h00, 32'd3, 4'b0000, 32'd0, "wr_tgt0_sel0");
    wb_xfer(1'b0, BASE + 32'h00, 32'd0, 4'hF, 32'h0009_0009, "rd_tgt0_sel0");

    // Reset pulse while idle with irq pending.
    chk("pre_rst_irq", irq, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("rst2_trim", trim, {3{16'h0040}});
    chk("rst2_busy", busy, 3'b000);
    chk("rst2_irq", irq, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wb_xfer(1'b0, BASE + 32'h40, 32'd0, 4'hF, 32'd3, "rd_div_rst2");
    wb_xfer(1'b0, BASE + 32'h00, 32'd0, 4'hF, 32'h0006_0006, "rd_tgt0_rst2");

    // Parallel channels with DIV=0: step every cycle.
    wb_xfer(1'b1, BASE + 32'h40, 32'd0, 4'b0011, 32'd0, "wr_div0");
    wb_xfer(1'b1, BASE + 32'h00, 32'd0, 4'b0001, 32'd0, "wr_tgt0_0");
    wb_xfer(1'b1, BASE + 32'h08, 32'd15, 4'b0001, 32'd0, "wr_tgt2_15");
    chk("par_a2_ch0", trim[15:0], 16'h0010);
    chk("par_a2_ch2", trim[47:32], 16'h0040);
    repeat (4) @(posedge clk);
    #1;
    chk("par_a6_ch0", trim[15:0], 16'h0001);
    chk("par_a6_ch2", trim[47:32], 16'h0400);
    chk("par_a6_busy", busy, 3'b100);
    chk("par_a6_irq", irq, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("par_a11_ch2", trim[47:32], 16'h8000);
    chk("par_a11_busy", busy, 3'b000);
    chk("par_a11_irq", irq, 1'b0);
    @(posedge clk);
    #1;
    chk("par_irq", irq, 1'b1);

    // Reset during a walk: ch0 0 -> 8, DIV=0.
    wb_xfer(1'b1, BASE + 32'h00, 32'd8, 4'b0001, 32'd0, "wr_tgt0_8");
    repeat (3) @(posedge clk);
    #1;
    chk("mw_cur3", trim[15:0], 16'h0008);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mw_rst_trim0", trim[15:0], 16'h0040);
    chk("mw_rst_busy", busy, 3'b000);
    chk("mw_rst_irq", irq, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("mw_after_trim", trim, {3{16'h0040}});
    chk("mw_after_busy", busy, 3'b000);
    wb_xfer(1'b0, BASE + 32'h00, 32'd0, 4'hF, 32'h0006_0006, "rd_tgt0_mw");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
